// File: rtl/cache_pkg.sv
// Shared cache definitions: command encoding and default geometry.
// Imported by the storage datapath and the cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        NOOP   = 2'b00,
        READ   = 2'b01,
        WRITE  = 2'b10,
        DELETE = 2'b11
    } operation_e;

    localparam int NUM_ENTRIES = 16;
    localparam int KEY_WIDTH   = 32;
    localparam int VALUE_WIDTH = 64;
    localparam int TTL_WIDTH   = 8;

    // Isolate the lowest set bit of a slot vector.
    function automatic logic [NUM_ENTRIES-1:0] lowest_bit(
        input logic [NUM_ENTRIES-1:0] v
    );
        return v & (~v + 1'b1);
    endfunction

endpackage

// File: rtl/cache_entry.sv
// One cache slot: key/value storage, valid bit, TTL counter, key compare.
// Write beats delete beats aging when several hit the same slot.
module cache_entry
    import cache_pkg::*;
#(
    parameter int KW = KEY_WIDTH,
    parameter int VW = VALUE_WIDTH,
    parameter int TW = TTL_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic          del_en_i,
    input  logic          tick_i,
    input  logic [KW-1:0] key_i,
    input  logic [VW-1:0] value_i,
    input  logic [TW-1:0] ttl_i,
    output logic          used_o,
    output logic          match_o,
    output logic [VW-1:0] value_o
);

    logic          used_q, used_d;
    logic [TW-1:0] ttl_q, ttl_d;
    logic [KW-1:0] key_q;
    logic [VW-1:0] value_q;

    always_comb begin
        used_d = used_q;
        ttl_d  = ttl_q;
        if (wr_en_i) begin
            used_d = 1'b1;
            ttl_d  = ttl_i;
        end else if (del_en_i) begin
            used_d = 1'b0;
            ttl_d  = '0;
        end else if (tick_i && used_q && ttl_q != '0) begin
            // A counter of 1 is the last live tick; 0 means immortal.
            ttl_d = ttl_q - 1'b1;
            if (ttl_q == TW'(1)) used_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= 1'b0;
            ttl_q  <= '0;
        end else begin
            used_q <= used_d;
            ttl_q  <= ttl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            key_q   <= key_i;
            value_q <= value_i;
        end
    end

    assign used_o  = used_q;
    assign match_o = used_q && (key_q == key_i);
    assign value_o = value_q;

endmodule

// File: rtl/cache_store.sv
// Cache entry array with command arbitration and registered lookup/delete responses.
// Match, slot choice and read data all come from pre-edge state.
module cache_store
    import cache_pkg::*;
#(
    parameter int NE = NUM_ENTRIES,
    parameter int KW = KEY_WIDTH,
    parameter int VW = VALUE_WIDTH,
    parameter int TW = TTL_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NE-1:0] idx_in,
    input  logic          write_in,
    input  logic          select_in,
    input  logic          delete_in,
    input  logic [KW-1:0] key_in,
    input  logic [VW-1:0] value_in,
    input  logic [TW-1:0] ttl_in,
    input  logic          tick_in,
    output logic [NE-1:0] used_out,
    output logic          full_out,
    output logic          rsp_valid_out,
    output logic          hit_out,
    output logic [NE-1:0] hit_idx_out,
    output logic [VW-1:0] rd_value_out,
    output logic          drop_out
);

    logic [NE-1:0] match, first_hit, free_pick;
    logic [NE-1:0] wr_en, del_en;
    logic [VW-1:0] ent_value [NE];
    logic [VW-1:0] rd_mux;
    logic          any_match;
    operation_e    op;

    logic          rsp_valid_q, rsp_valid_d;
    logic          hit_q, hit_d;
    logic [NE-1:0] hit_idx_q, hit_idx_d;
    logic [VW-1:0] rd_value_q, rd_value_d;
    logic          drop_q, drop_d;

    for (genvar i = 0; i < NE; i++) begin : g_entry
        cache_entry #(.KW(KW), .VW(VW), .TW(TW)) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (wr_en[i]),
            .del_en_i (del_en[i]),
            .tick_i   (tick_in),
            .key_i    (key_in),
            .value_i  (value_in),
            .ttl_i    (ttl_in),
            .used_o   (used_out[i]),
            .match_o  (match[i]),
            .value_o  (ent_value[i])
        );
    end

    assign first_hit = match & (~match + 1'b1);
    assign free_pick = idx_in & (~idx_in + 1'b1);
    assign any_match = |match;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NE; i++) begin
            if (first_hit[i]) rd_mux = rd_mux | ent_value[i];
        end
    end

    always_comb begin
        op = NOOP;
        if (write_in)       op = WRITE;
        else if (delete_in) op = DELETE;
        else if (select_in) op = READ;
    end

    always_comb begin
        wr_en       = '0;
        del_en      = '0;
        rsp_valid_d = 1'b0;
        hit_d       = 1'b0;
        hit_idx_d   = '0;
        rd_value_d  = '0;
        drop_d      = 1'b0;
        unique case (op)
            WRITE: begin
                // An existing key is updated in place, never duplicated.
                wr_en  = any_match ? first_hit : free_pick;
                drop_d = !any_match && (idx_in == '0);
            end
            DELETE: begin
                del_en      = first_hit;
                rsp_valid_d = 1'b1;
                hit_d       = any_match;
                hit_idx_d   = first_hit;
            end
            READ: begin
                rsp_valid_d = 1'b1;
                hit_d       = any_match;
                hit_idx_d   = first_hit;
                rd_value_d  = rd_mux;
            end
            NOOP: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_idx_q   <= '0;
            rd_value_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            hit_q       <= hit_d;
            hit_idx_q   <= hit_idx_d;
            rd_value_q  <= rd_value_d;
            drop_q      <= drop_d;
        end
    end

    assign full_out      = &used_out;
    assign rsp_valid_out = rsp_valid_q;
    assign hit_out       = hit_q;
    assign hit_idx_out   = hit_idx_q;
    assign rd_value_out  = rd_value_q;
    assign drop_out      = drop_q;

endmodule

// File: tb/tb_cache_store.sv
// Directed vector bench for cache_store: one command per cycle,
// outputs checked on the falling edge after the capturing edge.
module tb_cache_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] idx_in;
    logic        write_in, select_in, delete_in, tick_in;
    logic [31:0] key_in;
    logic [63:0] value_in;
    logic [7:0]  ttl_in;
    logic [15:0] used_out, hit_idx_out;
    logic        full_out, rsp_valid_out, hit_out, drop_out;
    logic [63:0] rd_value_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        w, s, d, t;
        logic [31:0] key;
        logic [63:0] val;
        logic [7:0]  ttl;
        logic [15:0] idx;
        logic [15:0] e_used;
        logic        e_rv, e_hit;
        logic [15:0] e_hidx;
        logic [63:0] e_rval;
        logic        e_drop;
    } vec_t;

    vec_t vq[$];

    cache_store dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .idx_in        (idx_in),
        .write_in      (write_in),
        .select_in     (select_in),
        .delete_in     (delete_in),
        .key_in        (key_in),
        .value_in      (value_in),
        .ttl_in        (ttl_in),
        .tick_in       (tick_in),
        .used_out      (used_out),
        .full_out      (full_out),
        .rsp_valid_out (rsp_valid_out),
        .hit_out       (hit_out),
        .hit_idx_out   (hit_idx_out),
        .rd_value_out  (rd_value_out),
        .drop_out      (drop_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(
        input logic w, s, d, t,
        input logic [31:0] key, input logic [63:0] val,
        input logic [7:0] ttl, input logic [15:0] idx,
        input logic [15:0] eu, input logic erv, ehit,
        input logic [15:0] ehidx, input logic [63:0] erval,
        input logic edrop
    );
        vec_t v;
        v.w = w; v.s = s; v.d = d; v.t = t;
        v.key = key; v.val = val; v.ttl = ttl; v.idx = idx;
        v.e_used = eu; v.e_rv = erv; v.e_hit = ehit;
        v.e_hidx = ehidx; v.e_rval = erval; v.e_drop = edrop;
        vq.push_back(v);
    endfunction

    task automatic idle();
        write_in = 0; select_in = 0; delete_in = 0; tick_in = 0;
        key_in = '0; value_in = '0; ttl_in = '0; idx_in = '0;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] eu,
                              input logic erv, ehit,
                              input logic [15:0] ehidx,
                              input logic [63:0] erval, input logic edrop);
        check({tag, ".used"},  64'(used_out), 64'(eu));
        check({tag, ".full"},  64'(full_out), 64'(&eu));
        check({tag, ".rv"},    64'(rsp_valid_out), 64'(erv));
        check({tag, ".hit"},   64'(hit_out), 64'(ehit));
        check({tag, ".hidx"},  64'(hit_idx_out), 64'(ehidx));
        check({tag, ".rval"},  rd_value_out, erval);
        check({tag, ".drop"},  64'(drop_out), 64'(edrop));
    endtask

    initial begin
        logic [15:0] acc;
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check_outs("reset", 16'h0, 0, 0, 16'h0, 64'h0, 0);
        rst_n = 1;
        @(negedge clk);
        check_outs("post_reset", 16'h0, 0, 0, 16'h0, 64'h0, 0);

        // w s d t key val ttl idx | used rv hit hidx rval drop
        add(1,0,0,0, 'hA5, 'h1234, 0, 'h0001, 'h0001, 0,0, 'h0, 'h0, 0);
        add(0,1,0,0, 'hA5, 0, 0, 0, 'h0001, 1,1, 'h0001, 'h1234, 0);
        add(0,1,0,0, 'hFF, 0, 0, 0, 'h0001, 1,0, 'h0, 'h0, 0);
        add(1,0,0,0, 'hA5, 'h9, 0, 'h0002, 'h0001, 0,0, 'h0, 'h0, 0);
        add(0,1,0,0, 'hA5, 0, 0, 0, 'h0001, 1,1, 'h0001, 'h9, 0);
        add(0,0,1,0, 'hFF, 0, 0, 0, 'h0001, 1,0, 'h0, 'h0, 0);
        add(1,1,0,0, 'hB0, 'h77, 0, 'h0002, 'h0003, 0,0, 'h0, 'h0, 0);
        add(0,1,1,0, 'hB0, 0, 0, 0, 'h0001, 1,1, 'h0002, 'h0, 0);
        acc = 16'h0001;
        for (int i = 1; i < 16; i++) begin
            acc = acc | (16'h1 << i);
            add(1,0,0,0, 32'h100 + i, 64'h1000 + i, 0, 16'h1 << i,
                acc, 0,0, 'h0, 'h0, 0);
        end
        add(0,1,0,0, 'h10A, 0, 0, 0, 'hFFFF, 1,1, 'h0400, 'h100A, 0);
        add(1,0,0,0, 'h999, 'h5, 0, 'h0000, 'hFFFF, 0,0, 'h0, 'h0, 1);
        add(0,0,0,0, 0, 0, 0, 0, 'hFFFF, 0,0, 'h0, 'h0, 0);
        add(0,0,1,0, 'h103, 0, 0, 0, 'hFFF7, 1,1, 'h0008, 'h0, 0);
        add(1,0,0,0, 'h88, 'h88, 0, 'h00F8, 'hFFFF, 0,0, 'h0, 'h0, 0);
        add(0,1,0,0, 'h88, 0, 0, 0, 'hFFFF, 1,1, 'h0008, 'h88, 0);
        add(0,0,1,0, 'h88, 0, 0, 0, 'hFFF7, 1,1, 'h0008, 'h0, 0);
        add(1,0,0,0, 'h55, 'h55, 2, 'h0008, 'hFFFF, 0,0, 'h0, 'h0, 0);
        add(0,0,0,1, 0, 0, 0, 0, 'hFFFF, 0,0, 'h0, 'h0, 0);
        add(0,1,0,1, 'h55, 0, 0, 0, 'hFFF7, 1,1, 'h0008, 'h55, 0);
        add(0,1,0,0, 'h55, 0, 0, 0, 'hFFF7, 1,0, 'h0, 'h0, 0);
        add(1,0,0,1, 'h66, 'h66, 1, 'h0008, 'hFFFF, 0,0, 'h0, 'h0, 0);
        add(0,0,0,1, 0, 0, 0, 0, 'hFFF7, 0,0, 'h0, 'h0, 0);
        add(1,0,0,0, 'h77, 'h77, 3, 'h0008, 'hFFFF, 0,0, 'h0, 'h0, 0);
        add(0,0,1,1, 'h77, 0, 0, 0, 'hFFF7, 1,1, 'h0008, 'h0, 0);
        add(0,1,0,0, 'hA5, 0, 0, 0, 'hFFF7, 1,1, 'h0001, 'h9, 0);

        foreach (vq[n]) begin
            write_in = vq[n].w; select_in = vq[n].s;
            delete_in = vq[n].d; tick_in = vq[n].t;
            key_in = vq[n].key; value_in = vq[n].val;
            ttl_in = vq[n].ttl; idx_in = vq[n].idx;
            @(negedge clk);
            check_outs($sformatf("vec%0d", n), vq[n].e_used, vq[n].e_rv,
                       vq[n].e_hit, vq[n].e_hidx, vq[n].e_rval,
                       vq[n].e_drop);
        end

        // Reset lands while a lookup is about to be captured.
        idle();
        select_in = 1; key_in = 'hA5;
        #2 rst_n = 0;
        @(negedge clk);
        check_outs("rst_mid", 16'h0, 0, 0, 16'h0, 64'h0, 0);
        idle();
        rst_n = 1;
        @(negedge clk);
        check_outs("rst_rel", 16'h0, 0, 0, 16'h0, 64'h0, 0);
        select_in = 1; key_in = 'hA5;
        @(negedge clk);
        check_outs("rst_look", 16'h0, 1, 0, 16'h0, 64'h0, 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
